vga_axil_slave: RTL and testbench
=================================

Name: vga_axil_slave

Overview:
- AXI4-Lite responder for the VGA controller. Terminates the CPU-side AW/W/B/AR/R channels.
- Drives the simplified register/buffer interface of the VGA top: write data, strobe, address, a write-ready pulse, a read request and a read address.
- Returns buffer read data to the bus.
- Sits between the SoC interconnect and the VGA top, in the same clk_i domain. Write pulses are stretched so the half-rate pixel-clock logic samples them.

Parameters:
- C_AXI_DATA_WIDTH, 32, bus data width.
- C_AXI_ADDR_WIDTH, 13, bus address width.
- WR_HOLD, 2, clk_i cycles axil_wready_o is held high per write (must be >=2).
- RD_LATENCY, 4, clk_i cycles from first axil_rreq_o cycle to axil_rdata_i valid.
- RREQ_HOLD, 2, clk_i cycles axil_rreq_o is held high.

Ports:
- clk_i  in  1  system clock (50 MHz)
- rstn_i  in  1  asynchronous active-low reset
- s_axil_awvalid_i / s_axil_awready_o  in/out  1  AW handshake
- s_axil_awaddr_i  in  C_AXI_ADDR_WIDTH  write address
- s_axil_wvalid_i / s_axil_wready_o  in/out  1  W handshake
- s_axil_wdata_i  in  C_AXI_DATA_WIDTH  write data
- s_axil_wstrb_i  in  C_AXI_DATA_WIDTH/8  write strobe
- s_axil_bvalid_o / s_axil_bready_i  out/in  1  B handshake
- s_axil_bresp_o  out  2  write response
- s_axil_arvalid_i / s_axil_arready_o  in/out  1  AR handshake
- s_axil_araddr_i  in  C_AXI_ADDR_WIDTH  read address
- s_axil_rvalid_o / s_axil_rready_i  out/in  1  R handshake
- s_axil_rdata_o  out  C_AXI_DATA_WIDTH  read data
- s_axil_rresp_o  out  2  read response
- axil_wdata_o  out  C_AXI_DATA_WIDTH  to VGA top
- axil_wstrb_o  out  C_AXI_DATA_WIDTH/8  to VGA top
- axil_waddr_o  out  C_AXI_ADDR_WIDTH  to VGA top
- axil_wready_o  out  1  write-commit pulse to VGA top
- axil_rreq_o  out  1  buffer read request
- axil_raddr_o  out  C_AXI_ADDR_WIDTH  buffer read address
- axil_rdata_i  in  C_AXI_DATA_WIDTH  buffer read data

Behaviour:
- Reset (async assert, sync deassert use): state IDLE. All valid/ready/pulse outputs 0. All data/address outputs 0. Resp 2'b00.
- Address map:
  - font 0x0000-0x07FF (bit12=0, bit11=0)
  - color regs 0x0800-0x0FFF (bit12=0, bit11=1)
  - text buffer 0x1000-0x195F (bit12=1, addr<6496)
  - 0x1960-0x1FFF is invalid.
- AW and W capture independently into holding regs:
  - awready_o=1 while AW holding reg empty and state IDLE.
  - wready_o=1 while W holding reg empty and state IDLE.
  - Each holding reg is cleared on entry to WRESP.
- AR captured with arready_o=1 only in IDLE with AR reg empty.
- Arbitration in IDLE:
  - Write pending (AW+W both held) or read pending (AR held).
  - If both are pending, grant the op not granted last time (round-robin flag; reset value favours write).
- WRITE:
  - Valid address: drive axil_waddr_o/wdata_o/wstrb_o from holding regs, stable for WR_HOLD cycles with axil_wready_o=1, then WRESP with bresp OKAY.
  - Invalid address: no axil_wready_o pulse, bresp SLVERR (2'b10), go straight to WRESP.
- WRESP: bvalid_o=1 until bready_i; then IDLE. bvalid is never dropped without bready.
- READ:
  - Only the buffer region is readable. Drive axil_raddr_o, axil_rreq_o=1 for RREQ_HOLD cycles.
  - Counter starts at the first rreq cycle. At count RD_LATENCY, register axil_rdata_i into rdata_o and go to RRESP with rresp OKAY.
  - Non-buffer address: no rreq, rdata_o=0, rresp SLVERR, immediate RRESP.
- RRESP: rvalid_o=1, rdata_o stable until rready_i; then IDLE.
- Only one transaction in flight. New AW/W/AR are not accepted until return to IDLE.
- Downstream address/data outputs hold their last value outside pulses.
- Reset mid-transaction aborts: no response is issued and pulses drop immediately.

Test Plan:
- Write 0x1000 data 0x41424344 strb 0xF, AW and W same cycle -> axil_wready_o high exactly 2 cycles with waddr 0x1000, data held; bvalid with bresp 00; a single B beat.
- W arrives 3 cycles before AW, address 0x0805, data 0x5 -> no commit until AW arrives; then 2-cycle pulse, OKAY.
- Read 0x1004 with axil_rdata_i=0x11223344 at latency 4 -> rreq high 2 cycles, raddr 0x1004, rdata_o 0x11223344, rresp 00. Hold rready low 5 cycles -> rvalid/rdata stable.
- Write 0x1960 and read 0x0010 -> no wready/rreq pulses; bresp 10, rresp 10, rdata 0.
- AW+W and AR valid same cycle after reset -> write serviced first, then read; repeat -> read first.
- Assert rstn_i low during the 2nd cycle of the WRITE hold -> axil_wready_o drops immediately, no bvalid. After release, all outputs are 0 and the block accepts a new write.

Source files
------------

// File: rtl/vga_axil_slave_if.sv
// AXI4-Lite bus between the SoC interconnect (master) and the VGA bridge (slave).
interface vga_axil_slave_if #(
    parameter int DW = 32,
    parameter int AW = 13
);
    logic          awvalid;
    logic          awready;
    logic [AW-1:0] awaddr;
    logic          wvalid;
    logic          wready;
    logic [DW-1:0] wdata;
    logic [DW/8-1:0] wstrb;
    logic          bvalid;
    logic          bready;
    logic [1:0]    bresp;
    logic          arvalid;
    logic          arready;
    logic [AW-1:0] araddr;
    logic          rvalid;
    logic          rready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/vga_axil_slave.sv
// AXI4-Lite responder feeding the VGA register/buffer port; one transaction in flight,
// write commits stretched over WR_HOLD cycles so the half-rate pixel logic can sample them.
module vga_axil_slave #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 13,
    parameter int WR_HOLD          = 2,
    parameter int RD_LATENCY       = 4,
    parameter int RREQ_HOLD        = 2
) (
    input  logic                            clk_i,
    input  logic                            rstn_i,
    vga_axil_slave_if.slave                 s_axil,
    output logic [C_AXI_DATA_WIDTH-1:0]     axil_wdata_o,
    output logic [C_AXI_DATA_WIDTH/8-1:0]   axil_wstrb_o,
    output logic [C_AXI_ADDR_WIDTH-1:0]     axil_waddr_o,
    output logic                            axil_wready_o,
    output logic                            axil_rreq_o,
    output logic [C_AXI_ADDR_WIDTH-1:0]     axil_raddr_o,
    input  logic [C_AXI_DATA_WIDTH-1:0]     axil_rdata_i
);
    localparam int DW = C_AXI_DATA_WIDTH;
    localparam int AW = C_AXI_ADDR_WIDTH;
    localparam logic [AW-1:0] BUF_BASE    = AW'(32'h0000_1000);
    localparam logic [AW-1:0] BUF_END     = AW'(32'h0000_1960);
    localparam logic [1:0]    RESP_OKAY   = 2'b00;
    localparam logic [1:0]    RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RRESP} state_t;

    state_t          state_r;
    logic            aw_full_r, w_full_r, ar_full_r;
    logic [AW-1:0]   aw_addr_r, ar_addr_r;
    logic [DW-1:0]   w_data_r;
    logic [DW/8-1:0] w_strb_r;
    logic            last_wr_r;
    logic [7:0]      cnt_r;
    logic            awready_r, wready_r, arready_r, bvalid_r, rvalid_r;
    logic [1:0]      bresp_r, rresp_r;
    logic [DW-1:0]   rdata_r;
    logic [DW-1:0]   axil_wdata_r;
    logic [DW/8-1:0] axil_wstrb_r;
    logic [AW-1:0]   axil_waddr_r, axil_raddr_r;
    logic            axil_wready_r, axil_rreq_r;

    logic aw_take_s, w_take_s, ar_take_s, wr_pend_s, rd_pend_s, grant_wr_s, grant_rd_s;

    // Everything except the 0x1960-0x1FFF hole is writable.
    function automatic logic wr_addr_ok(input logic [AW-1:0] a);
        return (a < BUF_END);
    endfunction

    function automatic logic rd_addr_ok(input logic [AW-1:0] a);
        return (a >= BUF_BASE) && (a < BUF_END);
    endfunction

    assign s_axil.awready = awready_r;
    assign s_axil.wready  = wready_r;
    assign s_axil.arready = arready_r;
    assign s_axil.bvalid  = bvalid_r;
    assign s_axil.bresp   = bresp_r;
    assign s_axil.rvalid  = rvalid_r;
    assign s_axil.rresp   = rresp_r;
    assign s_axil.rdata   = rdata_r;
    assign axil_wdata_o   = axil_wdata_r;
    assign axil_wstrb_o   = axil_wstrb_r;
    assign axil_waddr_o   = axil_waddr_r;
    assign axil_wready_o  = axil_wready_r;
    assign axil_rreq_o    = axil_rreq_r;
    assign axil_raddr_o   = axil_raddr_r;

    // Channel handshakes and round-robin grant; last_wr_r remembers the last contended winner.
    always_comb begin
        aw_take_s  = s_axil.awvalid && awready_r;
        w_take_s   = s_axil.wvalid  && wready_r;
        ar_take_s  = s_axil.arvalid && arready_r;
        wr_pend_s  = aw_full_r && w_full_r;
        rd_pend_s  = ar_full_r;
        grant_wr_s = 1'b0;
        grant_rd_s = 1'b0;
        if (state_r == IDLE) begin
            if (wr_pend_s && (!rd_pend_s || !last_wr_r)) begin
                grant_wr_s = 1'b1;
            end else if (rd_pend_s) begin
                grant_rd_s = 1'b1;
            end else begin
                grant_wr_s = 1'b0;
            end
        end else begin
            grant_rd_s = 1'b0;
        end
    end

    // Transaction FSM with holding registers and all registered outputs.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r       <= IDLE;
            aw_full_r     <= 1'b0;
            w_full_r      <= 1'b0;
            ar_full_r     <= 1'b0;
            aw_addr_r     <= '0;
            ar_addr_r     <= '0;
            w_data_r      <= '0;
            w_strb_r      <= '0;
            last_wr_r     <= 1'b0;
            cnt_r         <= 8'd0;
            awready_r     <= 1'b0;
            wready_r      <= 1'b0;
            arready_r     <= 1'b0;
            bvalid_r      <= 1'b0;
            rvalid_r      <= 1'b0;
            bresp_r       <= RESP_OKAY;
            rresp_r       <= RESP_OKAY;
            rdata_r       <= '0;
            axil_wdata_r  <= '0;
            axil_wstrb_r  <= '0;
            axil_waddr_r  <= '0;
            axil_raddr_r  <= '0;
            axil_wready_r <= 1'b0;
            axil_rreq_r   <= 1'b0;
        end else begin
            if (aw_take_s) begin
                aw_full_r <= 1'b1;
                aw_addr_r <= s_axil.awaddr;
            end
            if (w_take_s) begin
                w_full_r <= 1'b1;
                w_data_r <= s_axil.wdata;
                w_strb_r <= s_axil.wstrb;
            end
            if (ar_take_s) begin
                ar_full_r <= 1'b1;
                ar_addr_r <= s_axil.araddr;
            end
            case (state_r)
                IDLE: begin
                    if (grant_wr_s || grant_rd_s) begin
                        awready_r <= 1'b0;
                        wready_r  <= 1'b0;
                        arready_r <= 1'b0;
                        cnt_r     <= 8'd0;
                        if (wr_pend_s && rd_pend_s) begin
                            last_wr_r <= grant_wr_s;
                        end
                    end else begin
                        awready_r <= !(aw_full_r || aw_take_s);
                        wready_r  <= !(w_full_r || w_take_s);
                        arready_r <= !(ar_full_r || ar_take_s);
                    end
                    if (grant_wr_s) begin
                        if (wr_addr_ok(aw_addr_r)) begin
                            axil_waddr_r  <= aw_addr_r;
                            axil_wdata_r  <= w_data_r;
                            axil_wstrb_r  <= w_strb_r;
                            axil_wready_r <= 1'b1;
                            state_r       <= WRITE;
                        end else begin
                            aw_full_r <= 1'b0;
                            w_full_r  <= 1'b0;
                            bvalid_r  <= 1'b1;
                            bresp_r   <= RESP_SLVERR;
                            state_r   <= WRESP;
                        end
                    end else if (grant_rd_s) begin
                        if (rd_addr_ok(ar_addr_r)) begin
                            axil_raddr_r <= ar_addr_r;
                            axil_rreq_r  <= 1'b1;
                            state_r      <= READ;
                        end else begin
                            ar_full_r <= 1'b0;
                            rdata_r   <= '0;
                            rvalid_r  <= 1'b1;
                            rresp_r   <= RESP_SLVERR;
                            state_r   <= RRESP;
                        end
                    end
                end
                WRITE: begin
                    if (cnt_r == 8'(WR_HOLD - 1)) begin
                        axil_wready_r <= 1'b0;
                        aw_full_r     <= 1'b0;
                        w_full_r      <= 1'b0;
                        bvalid_r      <= 1'b1;
                        bresp_r       <= RESP_OKAY;
                        state_r       <= WRESP;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                WRESP: begin
                    if (s_axil.bready) begin
                        bvalid_r  <= 1'b0;
                        awready_r <= 1'b1;
                        wready_r  <= 1'b1;
                        arready_r <= !ar_full_r;
                        state_r   <= IDLE;
                    end
                end
                READ: begin
                    // cnt_r is 0 in the first rreq cycle, so the buffer data is sampled RD_LATENCY later
                    if (cnt_r == 8'(RREQ_HOLD - 1)) begin
                        axil_rreq_r <= 1'b0;
                    end
                    if (cnt_r == 8'(RD_LATENCY)) begin
                        rdata_r   <= axil_rdata_i;
                        rresp_r   <= RESP_OKAY;
                        rvalid_r  <= 1'b1;
                        ar_full_r <= 1'b0;
                        state_r   <= RRESP;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                RRESP: begin
                    if (s_axil.rready) begin
                        rvalid_r  <= 1'b0;
                        awready_r <= !aw_full_r;
                        wready_r  <= !w_full_r;
                        arready_r <= 1'b1;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vga_axil_slave.sv
// Self-checking bench for vga_axil_slave: directed vector table, hand-written reset/arbitration
// sequences, and randomized traffic checked against an address-map reference model.
module tb_vga_axil_slave;
    localparam int DW = 32, AW = 13, WR_HOLD = 2, RD_LATENCY = 4, RREQ_HOLD = 2;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    vga_axil_slave_if #(.DW(DW), .AW(AW)) bus();
    logic [DW-1:0]   axil_wdata;
    logic [DW/8-1:0] axil_wstrb;
    logic [AW-1:0]   axil_waddr, axil_raddr;
    logic            axil_wready, axil_rreq;
    logic [DW-1:0]   axil_rdata;

    vga_axil_slave #(.C_AXI_DATA_WIDTH(DW), .C_AXI_ADDR_WIDTH(AW), .WR_HOLD(WR_HOLD),
                     .RD_LATENCY(RD_LATENCY), .RREQ_HOLD(RREQ_HOLD)) dut (
        .clk_i(clk), .rstn_i(rstn), .s_axil(bus),
        .axil_wdata_o(axil_wdata), .axil_wstrb_o(axil_wstrb), .axil_waddr_o(axil_waddr),
        .axil_wready_o(axil_wready), .axil_rreq_o(axil_rreq), .axil_raddr_o(axil_raddr),
        .axil_rdata_i(axil_rdata)
    );

    int n_pass = 0, n_total = 0;
    bit wr_first_next;

    // Per-transaction observations.
    int wp, wp_bad, wp_first, aw_fire, w_fire, rq, rq_bad, rq_start;
    int b_cnt, b_first, r_cnt, r_first, r_unstable;
    logic [1:0]  bresp_seen, rresp_seen;
    logic [31:0] rdata_seen;
    bit timeout;

    typedef struct {
        bit          is_wr;
        logic [12:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_dly;
        int          w_dly;
        int          rdly;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: address map rules.
    function automatic logic [1:0] model_wr_resp(input int a);
        return (a < 6496) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [1:0] model_rd_resp(input int a);
        return (a >= 4096 && a < 6496) ? 2'b00 : 2'b10;
    endfunction

    task automatic check_zero(input string t);
        check({t, "_flags"}, {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid,
                              axil_wready, axil_rreq}, 64'd0);
        check({t, "_resp"}, {bus.bresp, bus.rresp}, 64'd0);
        check({t, "_wdata"}, {axil_wstrb, axil_wdata}, 64'd0);
        check({t, "_addr"}, {axil_waddr, axil_raddr}, 64'd0);
        check({t, "_rdata"}, bus.rdata, 64'd0);
    endtask

    task automatic idle_inputs();
        bus.awvalid = 1'b0; bus.awaddr = '0; bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
        bus.bready = 1'b0; bus.arvalid = 1'b0; bus.araddr = '0; bus.rready = 1'b0;
        axil_rdata = '0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        check_zero("reset");
        rstn = 1'b1;
        wr_first_next = 1'b1;
    endtask

    // Drives one write and/or one read, playing the buffer side, and records what it sees.
    task automatic run_txn(input bit do_wr, input bit do_rd,
                           input logic [AW-1:0] waddr, input logic [DW-1:0] wdata,
                           input logic [3:0] wstrb, input int aw_dly, input int w_dly,
                           input logic [AW-1:0] raddr, input logic [DW-1:0] mem, input int rdly);
        bit aw_done, w_done, b_done, ar_done, r_done;
        int tail, b_wait, r_wait;
        wp = 0; wp_bad = 0; wp_first = -1; aw_fire = -1; w_fire = -1;
        rq = 0; rq_bad = 0; rq_start = -1;
        b_cnt = 0; b_first = -1; r_cnt = 0; r_first = -1; r_unstable = 0;
        bresp_seen = 2'b11; rresp_seen = 2'b11; rdata_seen = 32'hFFFF_FFFF;
        aw_done = !do_wr; w_done = !do_wr; b_done = !do_wr;
        ar_done = !do_rd; r_done = !do_rd;
        tail = 0; b_wait = 0; r_wait = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (axil_wready) begin
                wp++;
                if (wp_first < 0) wp_first = c;
                if ({axil_waddr, axil_wdata, axil_wstrb} !== {waddr, wdata, wstrb}) wp_bad++;
            end
            if (axil_rreq) begin
                rq++;
                if (rq_start < 0) rq_start = c;
                if (axil_raddr !== raddr) rq_bad++;
            end
            axil_rdata = (rq_start >= 0 && c == rq_start + RD_LATENCY) ? mem : (32'hA5A5_0000 | 32'(c));
            if (bus.bvalid) begin
                b_cnt++;
                if (b_first < 0) begin b_first = c; bresp_seen = bus.bresp; end
            end
            if (bus.rvalid) begin
                r_cnt++;
                if (r_first < 0) begin
                    r_first = c; rresp_seen = bus.rresp; rdata_seen = bus.rdata;
                end else if (bus.rdata !== rdata_seen) begin
                    r_unstable++;
                end
            end
            bus.awvalid = !aw_done && c >= aw_dly; bus.awaddr = waddr;
            bus.wvalid  = !w_done && c >= w_dly;   bus.wdata = wdata; bus.wstrb = wstrb;
            bus.arvalid = !ar_done;                bus.araddr = raddr;
            if (bus.bvalid && !b_done) begin bus.bready = (b_wait >= rdly); b_wait++; end
            else bus.bready = 1'b0;
            if (bus.rvalid && !r_done) begin bus.rready = (r_wait >= rdly); r_wait++; end
            else bus.rready = 1'b0;
            if (bus.awvalid && bus.awready) begin aw_done = 1'b1; aw_fire = c; end
            if (bus.wvalid && bus.wready) begin w_done = 1'b1; w_fire = c; end
            if (bus.arvalid && bus.arready) ar_done = 1'b1;
            if (bus.bvalid && bus.bready) b_done = 1'b1;
            if (bus.rvalid && bus.rready) r_done = 1'b1;
            if (aw_done && w_done && b_done && ar_done && r_done) tail++;
            if (tail > 3) break;
        end
        timeout = !(aw_done && w_done && b_done && ar_done && r_done);
        idle_inputs();
    endtask

    task automatic chk_wr(input string t, input logic [1:0] exp_resp, input int rdly);
        bit ok;
        ok = (exp_resp == 2'b00);
        check({t, "_timeout"}, timeout, 64'd0);
        check({t, "_pulses"}, wp, ok ? WR_HOLD : 0);
        check({t, "_pulse_data"}, wp_bad, 64'd0);
        check({t, "_bresp"}, bresp_seen, exp_resp);
        check({t, "_bbeats"}, b_cnt, rdly + 1);
        if (ok) check({t, "_commit_after_aw_w"}, (wp_first > aw_fire) && (wp_first > w_fire), 64'd1);
    endtask

    task automatic chk_rd(input string t, input logic [1:0] exp_resp, input logic [31:0] exp_data,
                          input int rdly);
        bit ok;
        ok = (exp_resp == 2'b00);
        check({t, "_timeout"}, timeout, 64'd0);
        check({t, "_rreq_cycles"}, rq, ok ? RREQ_HOLD : 0);
        check({t, "_raddr"}, rq_bad, 64'd0);
        check({t, "_rresp"}, rresp_seen, exp_resp);
        check({t, "_rdata"}, rdata_seen, exp_data);
        check({t, "_rdata_stable"}, r_unstable, 64'd0);
        check({t, "_rbeats"}, r_cnt, rdly + 1);
    endtask

    initial begin
        int waited, bc, mode, dly;
        logic [12:0] a_w, a_r;
        logic [31:0] d, m;
        logic [3:0] s;
        bit exp_wr_first;

        vecs[0]  = '{1'b1, 13'h1000, 32'h4142_4344, 4'hF, 0, 0, 0, 2'b00, 32'h0};
        vecs[1]  = '{1'b1, 13'h0805, 32'h0000_0005, 4'h1, 3, 0, 1, 2'b00, 32'h0};
        vecs[2]  = '{1'b0, 13'h1004, 32'h1122_3344, 4'h0, 0, 0, 5, 2'b00, 32'h1122_3344};
        vecs[3]  = '{1'b1, 13'h1960, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b10, 32'h0};
        vecs[4]  = '{1'b0, 13'h0010, 32'h5566_7788, 4'h0, 0, 0, 0, 2'b10, 32'h0};
        vecs[5]  = '{1'b1, 13'h195F, 32'h0102_0304, 4'h3, 0, 2, 2, 2'b00, 32'h0};
        vecs[6]  = '{1'b0, 13'h195F, 32'hCAFE_F00D, 4'h0, 0, 0, 0, 2'b00, 32'hCAFE_F00D};
        vecs[7]  = '{1'b0, 13'h1960, 32'h1234_5678, 4'h0, 0, 0, 1, 2'b10, 32'h0};
        vecs[8]  = '{1'b0, 13'h0FFF, 32'h8765_4321, 4'h0, 0, 0, 0, 2'b10, 32'h0};
        vecs[9]  = '{1'b1, 13'h1FFF, 32'h0000_0000, 4'hF, 0, 0, 0, 2'b10, 32'h0};
        vecs[10] = '{1'b1, 13'h0000, 32'hA5A5_A5A5, 4'h8, 1, 0, 0, 2'b00, 32'h0};
        vecs[11] = '{1'b0, 13'h1000, 32'h0BAD_F00D, 4'h0, 0, 0, 3, 2'b00, 32'h0BAD_F00D};

        do_reset();

        // Contended arbitration: write wins first, read wins the next contention.
        run_txn(1'b1, 1'b1, 13'h1008, 32'h0000_00AA, 4'hF, 0, 0, 13'h1010, 32'h0000_00BB, 0);
        chk_wr("arb1_wr", 2'b00, 0);
        chk_rd("arb1_rd", 2'b00, 32'h0000_00BB, 0);
        check("arb1_write_first", (b_first >= 0) && (b_first < r_first), 64'd1);
        run_txn(1'b1, 1'b1, 13'h0004, 32'h0000_00CC, 4'hF, 0, 0, 13'h1014, 32'h0000_00DD, 0);
        chk_wr("arb2_wr", 2'b00, 0);
        chk_rd("arb2_rd", 2'b00, 32'h0000_00DD, 0);
        check("arb2_read_first", (r_first >= 0) && (r_first < b_first), 64'd1);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].is_wr) begin
                run_txn(1'b1, 1'b0, vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].aw_dly,
                        vecs[i].w_dly, 13'h0, 32'h0, vecs[i].rdly);
                chk_wr($sformatf("vec%0d", i), vecs[i].resp, vecs[i].rdly);
            end else begin
                run_txn(1'b0, 1'b1, 13'h0, 32'h0, 4'h0, 0, 0, vecs[i].addr, vecs[i].data,
                        vecs[i].rdly);
                chk_rd($sformatf("vec%0d", i), vecs[i].resp, vecs[i].rdata, vecs[i].rdly);
            end
        end

        // Reset during the second cycle of the write-commit pulse.
        @(negedge clk);
        bus.awvalid = 1'b1; bus.awaddr = 13'h1000; bus.wvalid = 1'b1;
        bus.wdata = 32'h7777_7777; bus.wstrb = 4'hF;
        waited = 0;
        while (!(bus.awready && bus.wready) && waited < 20) begin @(negedge clk); waited++; end
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        waited = 0;
        while (!axil_wready && waited < 20) begin @(negedge clk); waited++; end
        check("rstmid_pulse_seen", axil_wready, 64'd1);
        @(negedge clk);
        check("rstmid_pulse_2nd", axil_wready, 64'd1);
        rstn = 1'b0;
        #1;
        check("rstmid_wready_drop", axil_wready, 64'd0);
        check("rstmid_no_bvalid", bus.bvalid, 64'd0);
        idle_inputs();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        wr_first_next = 1'b1;
        #1;
        check_zero("rstmid_release");
        bc = 0;
        repeat (5) begin @(negedge clk); if (bus.bvalid) bc++; end
        check("rstmid_no_b_after", bc, 64'd0);
        run_txn(1'b1, 1'b0, 13'h0100, 32'h1357_9BDF, 4'hF, 0, 0, 13'h0, 32'h0, 0);
        chk_wr("rstmid_new_write", 2'b00, 0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 2);
            a_w  = 13'($urandom_range(0, 8191));
            a_r  = 13'($urandom_range(0, 8191));
            if (i % 4 == 0) a_r = 13'($urandom_range(4096, 6600));
            d = $urandom; m = $urandom; s = 4'($urandom_range(0, 15));
            dly = $urandom_range(0, 3);
            if (mode == 0) begin
                run_txn(1'b1, 1'b0, a_w, d, s, $urandom_range(0, 3), $urandom_range(0, 3),
                        13'h0, 32'h0, dly);
                chk_wr($sformatf("rnd%0d_w", i), model_wr_resp(int'(a_w)), dly);
            end else if (mode == 1) begin
                run_txn(1'b0, 1'b1, 13'h0, 32'h0, 4'h0, 0, 0, a_r, m, dly);
                chk_rd($sformatf("rnd%0d_r", i), model_rd_resp(int'(a_r)),
                       (model_rd_resp(int'(a_r)) == 2'b00) ? m : 32'h0, dly);
            end else begin
                exp_wr_first = wr_first_next;
                wr_first_next = !wr_first_next;
                run_txn(1'b1, 1'b1, a_w, d, s, 0, 0, a_r, m, dly);
                chk_wr($sformatf("rnd%0d_bw", i), model_wr_resp(int'(a_w)), dly);
                chk_rd($sformatf("rnd%0d_br", i), model_rd_resp(int'(a_r)),
                       (model_rd_resp(int'(a_r)) == 2'b00) ? m : 32'h0, dly);
                check($sformatf("rnd%0d_order", i), (b_first < r_first), exp_wr_first);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
